// File: rtl/bpsk_symbol_sequencer.sv
// ---------------------------------------------------------------------------
// bpsk_symbol_sequencer
//   Frame-level controller for the BPSK modulator. A frame is sent as an
//   alternating preamble, then FRAME_BITS payload bits pulled one at a time
//   over a valid/ready port, then silent guard symbols. Each symbol lasts SPS
//   clocks; sample_idx_sig walks the carrier LUT and phase_sig selects the
//   normal (0) or inverted (1) carrier for the current symbol.
//
// Ports
//   clk_sig         in   system clock, rising edge
//   reset_sig       in   asynchronous active-low reset
//   start_sig       in   frame request, sampled only while idle
//   data_sig        in   payload bit (1 -> inverted carrier)
//   data_valid_sig  in   data_sig valid
//   data_ready_sig  out  sequencer accepts data_sig this cycle
//   sample_idx_sig  out  carrier sample index within the current symbol
//   phase_sig       out  carrier phase select for the current symbol
//   sym_strobe_sig  out  first sample of each preamble/payload symbol
//   tx_en_sig       out  modulator output enable
//   busy_sig        out  frame in progress
//   done_sig        out  one-cycle pulse on the last cycle of a frame
//   underrun_sig    out  sticky: a payload bit was missing at its symbol start
// ---------------------------------------------------------------------------
module bpsk_symbol_sequencer #(
    parameter int SPS          = 16,
    parameter int PREAMBLE_LEN = 8,
    parameter int FRAME_BITS   = 32,
    parameter int GAP_SYMS     = 2
) (
    input  logic                   clk_sig,
    input  logic                   reset_sig,
    input  logic                   start_sig,
    input  logic                   data_sig,
    input  logic                   data_valid_sig,
    output logic                   data_ready_sig,
    output logic [$clog2(SPS)-1:0] sample_idx_sig,
    output logic                   phase_sig,
    output logic                   sym_strobe_sig,
    output logic                   tx_en_sig,
    output logic                   busy_sig,
    output logic                   done_sig,
    output logic                   underrun_sig
);

    localparam int IW       = $clog2(SPS);
    localparam int MAX_A    = (PREAMBLE_LEN > FRAME_BITS) ? PREAMBLE_LEN : FRAME_BITS;
    localparam int MAX_SYMS = (MAX_A > GAP_SYMS) ? MAX_A : GAP_SYMS;
    localparam int SW       = $clog2(MAX_SYMS + 1);
    localparam int FW       = $clog2(FRAME_BITS + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(SPS - 1);
    localparam logic [SW-1:0] LAST_PRE  = SW'(PREAMBLE_LEN - 1);
    localparam logic [SW-1:0] LAST_DATA = SW'(FRAME_BITS - 1);
    localparam logic [SW-1:0] LAST_GAP  = SW'(GAP_SYMS - 1);
    localparam logic [FW-1:0] FETCH_MAX = FW'(FRAME_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_GAP
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] sym_q, sym_d;
    logic [FW-1:0] fetch_q, fetch_d;
    logic          buf_full_q, buf_full_d;
    logic          buf_bit_q, buf_bit_d;
    logic          phase_q, phase_d;
    logic          underrun_q, underrun_d;
    logic          ready_q, ready_d;
    logic          strobe_q, strobe_d;
    logic          tx_en_q, tx_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          xfer;
    logic          consume;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        sym_d      = sym_q;
        fetch_d    = fetch_q;
        buf_full_d = buf_full_q;
        buf_bit_d  = buf_bit_q;
        phase_d    = phase_q;
        underrun_d = underrun_q;
        consume    = 1'b0;

        xfer = data_valid_sig && ready_q;
        if (xfer) begin
            fetch_d    = fetch_q + FW'(1);
            buf_full_d = 1'b1;
            buf_bit_d  = data_sig;
        end

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start_sig) begin
                    state_d    = S_PREAMBLE;
                    sym_d      = '0;
                    fetch_d    = '0;
                    buf_full_d = 1'b0;
                    phase_d    = 1'b1;      // preamble symbol 0 is even
                    underrun_d = 1'b0;
                end
            end
            default: begin
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    sym_d = sym_q + SW'(1);
                    case (state_q)
                        S_PREAMBLE: begin
                            if (sym_q == LAST_PRE) begin
                                state_d = S_DATA;
                                sym_d   = '0;
                                consume = 1'b1;
                            end else begin
                                phase_d = ~sym_d[0];
                            end
                        end
                        S_DATA: begin
                            if (sym_q == LAST_DATA) begin
                                state_d = S_GAP;
                                sym_d   = '0;
                                phase_d = 1'b0;
                            end else begin
                                consume = 1'b1;
                            end
                        end
                        S_GAP: begin
                            if (sym_q == LAST_GAP) begin
                                state_d = S_IDLE;
                                sym_d   = '0;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase

        // Entering a payload symbol: take the buffered bit, or the bit arriving
        // this very cycle, or flag an underrun and burn the slot so the frame
        // length never changes.
        if (consume) begin
            if (buf_full_q) begin
                phase_d    = buf_bit_q;
                buf_full_d = 1'b0;
            end else if (xfer) begin
                phase_d    = data_sig;
                buf_full_d = 1'b0;
            end else begin
                phase_d    = 1'b0;
                underrun_d = 1'b1;
                fetch_d    = fetch_q + FW'(1);
            end
        end

        // Status outputs are computed from next state so they leave flops.
        busy_d   = (state_d != S_IDLE);
        tx_en_d  = (state_d == S_PREAMBLE) || (state_d == S_DATA);
        strobe_d = tx_en_d && (idx_d == '0);
        done_d   = (state_d == S_GAP) && (idx_d == LAST_IDX) && (sym_d == LAST_GAP);
        ready_d  = busy_d && !buf_full_d && (fetch_d < FETCH_MAX);
    end

    // NOTE: reset is asynchronous so outputs drop the instant reset_sig goes low;
    // every flop here is control state, so all of them are reset.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            sym_q      <= '0;
            fetch_q    <= '0;
            buf_full_q <= 1'b0;
            buf_bit_q  <= 1'b0;
            phase_q    <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
            strobe_q   <= 1'b0;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            idx_q      <= idx_d;
            sym_q      <= sym_d;
            fetch_q    <= fetch_d;
            buf_full_q <= buf_full_d;
            buf_bit_q  <= buf_bit_d;
            phase_q    <= phase_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            strobe_q   <= strobe_d;
            tx_en_q    <= tx_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign data_ready_sig = ready_q;
    assign sample_idx_sig = idx_q;
    assign phase_sig      = phase_q;
    assign sym_strobe_sig = strobe_q;
    assign tx_en_sig      = tx_en_q;
    assign busy_sig       = busy_q;
    assign done_sig       = done_q;
    assign underrun_sig   = underrun_q;

endmodule

// File: tb/tb_bpsk_symbol_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bpsk_symbol_sequencer
//   Directed bench for bpsk_symbol_sequencer at its default parameters.
// ---------------------------------------------------------------------------
module tb_bpsk_symbol_sequencer;

    localparam int SPS       = 16;
    localparam int PRE       = 8;
    localparam int FB        = 32;
    localparam int GAP       = 2;
    localparam int FRAME_CYC = (PRE + FB + GAP) * SPS;   // 672
    localparam int M_NOM     = 0;
    localparam int M_STALL   = 1;
    localparam int M_BYPASS  = 2;

    logic       clk_sig = 1'b0;
    logic       reset_sig;
    logic       start_sig;
    logic       data_sig;
    logic       data_valid_sig;
    logic       data_ready_sig;
    logic [3:0] sample_idx_sig;
    logic       phase_sig;
    logic       sym_strobe_sig;
    logic       tx_en_sig;
    logic       busy_sig;
    logic       done_sig;
    logic       underrun_sig;

    int vectors     = 0;
    int miscompares = 0;

    bpsk_symbol_sequencer #(
        .SPS(SPS), .PREAMBLE_LEN(PRE), .FRAME_BITS(FB), .GAP_SYMS(GAP)
    ) dut (
        .clk_sig        (clk_sig),
        .reset_sig      (reset_sig),
        .start_sig      (start_sig),
        .data_sig       (data_sig),
        .data_valid_sig (data_valid_sig),
        .data_ready_sig (data_ready_sig),
        .sample_idx_sig (sample_idx_sig),
        .phase_sig      (phase_sig),
        .sym_strobe_sig (sym_strobe_sig),
        .tx_en_sig      (tx_en_sig),
        .busy_sig       (busy_sig),
        .done_sig       (done_sig),
        .underrun_sig   (underrun_sig)
    );

    always #5 clk_sig = ~clk_sig;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Payload source: 0xA5A5_A5A5 sent MSB first.
    function automatic logic src_bit(input int p);
        logic [31:0] w;
        w = 32'hA5A5_A5A5;
        return (p < 32) ? w[31-p] : 1'b0;
    endfunction

    function automatic logic [31:0] out_bus();
        return {21'd0, data_ready_sig, sample_idx_sig, phase_sig, sym_strobe_sig,
                tx_en_sig, busy_sig, done_sig, underrun_sig};
    endfunction

    task automatic tick();
        @(posedge clk_sig);
        #1;
    endtask

    // Runs one full frame from IDLE with the given source behaviour and checks it.
    task automatic run_frame(input int mode, input string tag);
        int          busy_cyc, strobes, dones, done_idx, ptr, guard, tx_cyc, gap_phase;
        logic        xfer;
        logic [7:0]  pre_ph;
        logic [31:0] pay_ph, exp_pay;
        busy_cyc = 0; strobes = 0; dones = 0; done_idx = 0; ptr = 0; guard = 0;
        tx_cyc = 0; gap_phase = 0; pre_ph = '0; pay_ph = '0;
        start_sig = 1'b1;
        data_valid_sig = 1'b0;
        tick();
        start_sig = 1'b0;
        check({tag, "_first_idx"}, 32'(sample_idx_sig), 32'd0);
        check({tag, "_first_underrun"}, 32'(underrun_sig), 32'd0);
        while (busy_sig && guard < 4 * FRAME_CYC) begin
            busy_cyc++;
            if (tx_en_sig) tx_cyc++;
            else if (phase_sig) gap_phase++;
            if (sym_strobe_sig) begin
                if (strobes < PRE) pre_ph[PRE-1-strobes] = phase_sig;
                else if (strobes < PRE + FB) pay_ph[31-(strobes-PRE)] = phase_sig;
                strobes++;
            end
            if (done_sig) begin
                dones++;
                done_idx = int'(sample_idx_sig);
            end
            case (mode)
                M_STALL:  data_valid_sig = (ptr != 5) || (strobes == PRE + 6 && sample_idx_sig >= 4'd3);
                M_BYPASS: data_valid_sig = (ptr != 7) || (strobes == PRE + 7 && sample_idx_sig == 4'(SPS-1));
                default:  data_valid_sig = 1'b1;
            endcase
            data_sig = src_bit(ptr);
            xfer = data_valid_sig && data_ready_sig;
            tick();
            if (xfer) ptr++;
            guard++;
        end
        data_valid_sig = 1'b0;
        check({tag, "_terminated"}, 32'(busy_sig), 32'd0);

        exp_pay = '0;
        for (int k = 0; k < FB; k++) begin
            if (mode == M_STALL)
                exp_pay[31-k] = (k < 5) ? src_bit(k) : (k == 5) ? 1'b0 : src_bit(k - 1);
            else
                exp_pay[31-k] = src_bit(k);
        end

        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(FRAME_CYC));
        check({tag, "_strobes"}, 32'(strobes), 32'(PRE + FB));
        check({tag, "_preamble"}, 32'(pre_ph), 32'h0000_00AA);
        check({tag, "_payload"}, pay_ph, exp_pay);
        check({tag, "_dones"}, 32'(dones), 32'd1);
        check({tag, "_done_idx"}, 32'(done_idx), 32'(SPS - 1));
        check({tag, "_tx_cycles"}, 32'(tx_cyc), 32'((PRE + FB) * SPS));
        check({tag, "_gap_phase"}, 32'(gap_phase), 32'd0);
        check({tag, "_underrun"}, 32'(underrun_sig), (mode == M_STALL) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int guard, len1, len2, idle_gap, strobes, bad;

        // Reset
        reset_sig = 1'b0; start_sig = 1'b0; data_sig = 1'b0; data_valid_sig = 1'b0;
        repeat (4) tick();
        check("reset_outputs", out_bus(), 32'd0);
        reset_sig = 1'b1;
        repeat (5) tick();
        check("idle_busy", 32'(busy_sig), 32'd0);
        check("idle_idx", 32'(sample_idx_sig), 32'd0);

        run_frame(M_NOM, "nominal");
        run_frame(M_STALL, "stall");
        repeat (3) tick();
        check("underrun_sticky_idle", 32'(underrun_sig), 32'd1);
        run_frame(M_BYPASS, "bypass");

        // Back-to-back frames with start held high; source never valid.
        start_sig = 1'b1;
        guard = 0;
        do begin tick(); guard++; end while (!busy_sig && guard < 10);
        len1 = 0; guard = 0;
        while (busy_sig && guard < 4 * FRAME_CYC) begin len1++; tick(); guard++; end
        idle_gap = 0; guard = 0;
        while (!busy_sig && guard < 10) begin idle_gap++; tick(); guard++; end
        start_sig = 1'b0;
        len2 = 0; guard = 0;
        while (busy_sig && guard < 4 * FRAME_CYC) begin len2++; tick(); guard++; end
        check("b2b_len1", 32'(len1), 32'(FRAME_CYC));
        check("b2b_idle_gap", 32'(idle_gap), 32'd1);
        check("b2b_len2", 32'(len2), 32'(FRAME_CYC));
        check("b2b_underrun", 32'(underrun_sig), 32'd1);
        repeat (2) tick();
        check("b2b_idle_after", 32'(busy_sig), 32'd0);

        // Reset mid-frame at payload symbol 10.
        start_sig = 1'b1;
        tick();
        start_sig = 1'b0;
        data_valid_sig = 1'b1;
        data_sig = 1'b1;
        strobes = 0; guard = 0;
        while (!(strobes == PRE + 11 && sample_idx_sig == 4'd5) && guard < 4 * FRAME_CYC) begin
            if (sym_strobe_sig) strobes++;
            tick();
            guard++;
        end
        check("rst_mid_reached", 32'(guard < 4 * FRAME_CYC), 32'd1);
        #2 reset_sig = 1'b0;
        #1 check("rst_mid_async_outputs", out_bus(), 32'd0);
        data_valid_sig = 1'b0;
        bad = 0;
        repeat (3) begin
            tick();
            if (done_sig || busy_sig) bad++;
        end
        check("rst_mid_no_done", 32'(bad), 32'd0);
        reset_sig = 1'b1;
        repeat (3) tick();
        check("rst_mid_idle", out_bus(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
